// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared constants and helpers for the barrel slot scheduler
package barrel_pkg;

    localparam int SLOT_NUM_DEFAULT = 16;

    // Spawner FSM states
    typedef logic [0:0] spawn_state_t;
    localparam spawn_state_t IDLE = 1'b0;
    localparam spawn_state_t HOLD = 1'b1;

    // Barrel instance state encodings
    typedef enum logic [1:0] {
        BARREL_OFF    = 2'd0,
        BARREL_LAUNCH = 2'd1,
        BARREL_ROLL   = 2'd2,
        BARREL_FALL   = 2'd3
    } barrel_state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, v} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/slot_picker.sv
// rtl/slot_picker.sv - round-robin free-slot finder: rotate, priority-encode, un-rotate
module slot_picker #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] free_mask,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot;
    logic [W-1:0] j;
    logic [W-1:0] pe;

    always_comb begin
        rot = '0;
        j   = '0;
        pe  = '0;
        for (int i = 0; i < N; i++) begin
            j      = W'(i) + ptr;
            rot[i] = free_mask[j];
        end
        // Descending scan leaves the lowest set bit, i.e. the nearest slot at or after ptr
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pe = W'(i);
        end
    end

    assign found = |free_mask;
    assign idx   = pe + ptr;

endmodule

// File: rtl/barrel_spawner.sv
// rtl/barrel_spawner.sv - turns Kong drop edges into round-robin barrel slot launches
module barrel_spawner
    import barrel_pkg::*;
#(
    parameter int SLOT_NUM = SLOT_NUM_DEFAULT,
    parameter int MIN_GAP  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                clear,
    input  logic                enable,
    input  logic                drop_req,
    input  logic [SLOT_NUM-1:0] slot_done,
    output logic [SLOT_NUM-1:0] slot_start,
    output logic [SLOT_NUM-1:0] busy,
    output logic [4:0]          active_count,
    output logic                drop_ack,
    output logic [7:0]          miss_count
);

    localparam int IW = $clog2(SLOT_NUM);
    localparam int GW = $clog2(MIN_GAP + 1);

    spawn_state_t        state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       hold_idx_q, hold_idx_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                pending_q, pending_d;
    logic                drop_prev_q, drop_prev_d;
    logic [SLOT_NUM-1:0] busy_q, busy_d;
    logic [SLOT_NUM-1:0] slot_start_q, slot_start_d;
    logic                drop_ack_q, drop_ack_d;
    logic [7:0]          miss_q, miss_d;
    logic [4:0]          active_q, active_d;

    logic [SLOT_NUM-1:0] free_mask;
    logic [SLOT_NUM-1:0] done_mask;
    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic                drop_evt, pend_eff, evt_miss, full_miss;

    assign free_mask = ~busy_q;

    slot_picker #(.N(SLOT_NUM), .W(IW)) u_picker (
        .free_mask (free_mask),
        .ptr       (ptr_q),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    assign drop_evt = enable & drop_req & ~drop_prev_q;
    assign pend_eff = pending_q | drop_evt;
    assign evt_miss = drop_evt & pending_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_idx_d   = hold_idx_q;
        gap_d        = gap_q;
        pending_d    = pending_q;
        drop_prev_d  = drop_prev_q;
        busy_d       = busy_q;
        slot_start_d = slot_start_q;
        drop_ack_d   = 1'b0;
        miss_d       = miss_q;
        done_mask    = '0;
        full_miss    = 1'b0;
        if (tick) begin
            drop_prev_d = drop_req;
            pending_d   = pend_eff;
            // The slot in HOLD has not launched yet, so its done is stale
            done_mask = slot_done & busy_q;
            if (state_q == HOLD) done_mask[hold_idx_q] = 1'b0;
            busy_d = busy_q & ~done_mask;
            if (state_q == IDLE) begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (pend_eff && enable && pick_found) begin
                    busy_d[pick_idx]       = 1'b1;
                    slot_start_d           = '0;
                    slot_start_d[pick_idx] = 1'b1;
                    hold_idx_d             = pick_idx;
                    drop_ack_d             = 1'b1;
                    pending_d              = 1'b0;
                    state_d                = HOLD;
                end else if (pend_eff && enable) begin
                    full_miss = 1'b1;
                    pending_d = 1'b0;
                end
            end else begin
                slot_start_d = '0;
                ptr_d        = hold_idx_q + IW'(1);
                gap_d        = GW'(MIN_GAP);
                state_d      = IDLE;
            end
            miss_d = sat_add8(miss_q, {1'b0, evt_miss} + {1'b0, full_miss});
        end
        active_d = '0;
        for (int i = 0; i < SLOT_NUM; i++) begin
            active_d = active_d + 5'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            hold_idx_q   <= '0;
            gap_q        <= '0;
            pending_q    <= 1'b0;
            drop_prev_q  <= 1'b0;
            busy_q       <= '0;
            slot_start_q <= '0;
            drop_ack_q   <= 1'b0;
            miss_q       <= '0;
            active_q     <= '0;
        end else if (clear) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            hold_idx_q   <= '0;
            gap_q        <= '0;
            pending_q    <= 1'b0;
            drop_prev_q  <= 1'b0;
            busy_q       <= '0;
            slot_start_q <= '0;
            drop_ack_q   <= 1'b0;
            miss_q       <= '0;
            active_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_idx_q   <= hold_idx_d;
            gap_q        <= gap_d;
            pending_q    <= pending_d;
            drop_prev_q  <= drop_prev_d;
            busy_q       <= busy_d;
            slot_start_q <= slot_start_d;
            drop_ack_q   <= drop_ack_d;
            miss_q       <= miss_d;
            active_q     <= active_d;
        end
    end

    assign slot_start   = slot_start_q;
    assign busy         = busy_q;
    assign active_count = active_q;
    assign drop_ack     = drop_ack_q;
    assign miss_count   = miss_q;

endmodule

// File: tb/tb_barrel_spawner.sv
// tb/tb_barrel_spawner.sv - self-checking bench for barrel_spawner
module tb_barrel_spawner;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic         clear;
    logic         enable;
    logic         drop_req;
    logic [N-1:0] slot_done;
    logic [N-1:0] slot_start;
    logic [N-1:0] busy;
    logic [4:0]   active_count;
    logic         drop_ack;
    logic [7:0]   miss_count;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] sb_q[$];

    typedef struct {
        logic         drop;
        logic [N-1:0] done;
        logic [N-1:0] start;
        logic [N-1:0] busy;
        logic [4:0]   act;
        logic [7:0]   miss;
        logic         ack;
    } vec_t;

    vec_t tbl[24];

    barrel_spawner #(.SLOT_NUM(N), .MIN_GAP(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .clear        (clear),
        .enable       (enable),
        .drop_req     (drop_req),
        .slot_done    (slot_done),
        .slot_start   (slot_start),
        .busy         (busy),
        .active_count (active_count),
        .drop_ack     (drop_ack),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; tick covers exactly one posedge, returns at the next negedge
    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    always @(negedge clk) begin
        if (drop_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_grant: got slot_start %0h expected no grant", slot_start);
            end else begin
                chk("sb_slot_start", 32'(slot_start), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b0; clear = 1'b0; enable = 1'b1; drop_req = 1'b0; slot_done = '0;

        for (int i = 0; i < 24; i++)
            tbl[i] = '{drop: 1'b0, done: '0, start: '0, busy: '0, act: 5'd0, miss: 8'd0, ack: 1'b0};
        for (int i = 2; i <= 11; i++) begin tbl[i].busy = 16'h0001; tbl[i].act = 5'd1; end
        for (int i = 4; i <= 13; i++) tbl[i].drop = 1'b1;
        for (int i = 17; i <= 23; i++) tbl[i].miss = 8'd1;
        tbl[2].drop  = 1'b1; tbl[2].start  = 16'h0001; tbl[2].ack  = 1'b1;
        tbl[12].start = 16'h0002; tbl[12].busy = 16'h0003; tbl[12].act = 5'd2; tbl[12].ack = 1'b1;
        tbl[13].done = 16'h0003; tbl[13].busy = 16'h0002; tbl[13].act = 5'd1;
        tbl[14].done = 16'h0002;
        tbl[15].drop = 1'b1;
        tbl[17].drop = 1'b1;
        tbl[18].done = 16'h0100;
        tbl[22].start = 16'h0004; tbl[22].busy = 16'h0004; tbl[22].act = 5'd1; tbl[22].ack = 1'b1;
        tbl[23].busy = 16'h0004; tbl[23].act = 5'd1;

        repeat (2) @(negedge clk);
        chk("rst_slot_start", 32'(slot_start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_active", 32'(active_count), 32'h0);
        chk("rst_ack", 32'(drop_ack), 32'h0);
        chk("rst_miss", 32'(miss_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic grant, round-robin with gap, HOLD-slot done ignored, double event miss
        for (int i = 0; i < 24; i++) begin
            drop_req  = tbl[i].drop;
            slot_done = tbl[i].done;
            if (tbl[i].ack) sb_q.push_back(tbl[i].start);
            do_tick();
            chk($sformatf("t%0d_start", i + 1), 32'(slot_start), 32'(tbl[i].start));
            chk($sformatf("t%0d_busy", i + 1), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("t%0d_active", i + 1), 32'(active_count), 32'(tbl[i].act));
            chk($sformatf("t%0d_miss", i + 1), 32'(miss_count), 32'(tbl[i].miss));
            chk($sformatf("t%0d_ack", i + 1), 32'(drop_ack), 32'(tbl[i].ack));
        end
        slot_done = '0;
        drop_req  = 1'b0;

        // Full pool
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        for (int s = 0; s < N; s++) begin
            drop_req = 1'b1;
            sb_q.push_back(N'(1) << s);
            do_tick();
            drop_req = 1'b0;
            repeat (9) do_tick();
        end
        chk("full_busy", 32'(busy), 32'hFFFF);
        chk("full_active", 32'(active_count), 32'd16);
        drop_req = 1'b1; do_tick();
        chk("full_miss", 32'(miss_count), 32'd1);
        chk("full_no_start", 32'(slot_start), 32'h0);
        drop_req = 1'b0; slot_done = 16'h0020; do_tick(); slot_done = '0;
        chk("full_done5_busy", 32'(busy), 32'hFFDF);
        chk("full_done5_active", 32'(active_count), 32'd15);
        drop_req = 1'b1; sb_q.push_back(16'h0020); do_tick();
        chk("full_regrant_busy", 32'(busy), 32'hFFFF);
        drop_req = 1'b0; do_tick();
        chk("full_hold_end_start", 32'(slot_start), 32'h0);
        repeat (8) do_tick();

        // Saturation
        for (int i = 0; i < 300; i++) begin
            drop_req = 1'b1; do_tick();
            drop_req = 1'b0; do_tick();
            if (i == 99) chk("sat_mid_miss", 32'(miss_count), 32'd101);
        end
        chk("sat_miss", 32'(miss_count), 32'd255);

        clear = 1'b1; @(negedge clk); clear = 1'b0;
        chk("clr_miss", 32'(miss_count), 32'h0);
        chk("clr_busy", 32'(busy), 32'h0);
        chk("clr_active", 32'(active_count), 32'h0);

        // Clear during HOLD
        drop_req = 1'b1; sb_q.push_back(16'h0001); do_tick();
        chk("clrhold_pre_start", 32'(slot_start), 32'h0001);
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        chk("clrhold_start", 32'(slot_start), 32'h0);
        chk("clrhold_busy", 32'(busy), 32'h0);
        chk("clrhold_active", 32'(active_count), 32'h0);

        // Async reset during HOLD, while drop_ack is still high
        drop_req = 1'b0; do_tick();
        drop_req = 1'b1; sb_q.push_back(16'h0001); do_tick();
        chk("rsthold_pre_start", 32'(slot_start), 32'h0001);
        #2 rst = 1'b1;
        #1;
        chk("rsthold_start", 32'(slot_start), 32'h0);
        chk("rsthold_busy", 32'(busy), 32'h0);
        chk("rsthold_active", 32'(active_count), 32'h0);
        chk("rsthold_ack", 32'(drop_ack), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        drop_req = 1'b0; do_tick();
        drop_req = 1'b1; sb_q.push_back(16'h0001); do_tick();
        chk("after_rst_busy", 32'(busy), 32'h0001);
        drop_req = 1'b0; do_tick();
        chk("after_rst_start_off", 32'(slot_start), 32'h0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_spawner.md
# barrel_spawner

Slot scheduler for the barrel pool. It turns Kong's drop animation into barrel launches, allocating a free barrel slot round-robin. It also tracks which slots are in flight, enforces a minimum spacing between launches, and counts drops that could not be served. It sits between the kong and barrel instances and replaces the free-running drop counter that indexes barrel start lines blindly.

## Interface
- `SLOT_NUM`, 16: number of barrel slots; must be a power of two, 2–16.
- `MIN_GAP`, 8: game ticks that must elapse after a launch completes before the next grant.
- `clk` input 1: system clock.
- `rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `tick` input 1: one-`clk` pulse per game tick, aligned to the slow game clock's rising edge. All scheduling state advances only when `tick=1`.
- `clear` input 1: synchronous clear for game-initial state. Takes effect on any `clk` cycle, tick or not.
- `enable` input 1: game running. When low, no new grants and no pending capture; busy tracking continues.
- `drop_req` input 1: level, high while Kong is in the drop animation.
- `slot_done` input SLOT_NUM: per-slot "barrel finished" (off-screen or over), sampled on tick.
- `slot_start` output SLOT_NUM: one-hot start to the barrel instances.
- `busy` output SLOT_NUM: slot owns a live barrel.
- `active_count` output 5: registered popcount of `busy`.
- `drop_ack` output 1: one-`clk` pulse on each grant.
- `miss_count` output 8: saturating count of unserved drop events.

## Operation
**Reset and clear.** `rst` (async) and `clear` (sync) drive all outputs and internal state to zero:
- `slot_start`, `busy`, `active_count`, `drop_ack`, `miss_count`, pointer `ptr`, `gap`, `pending`, `drop_prev`.
- FSM to `IDLE`.

**Drop edge.** Evaluated only on a tick with `enable=1`:
- `drop_req=1` and `drop_prev=0` is a drop event; `drop_prev` takes `drop_req` every tick.
- Event with `pending=0`: set `pending`.
- Event with `pending=1`: `miss_count++` (saturate at 255).

**FSM `IDLE`,** on tick:
- If `gap>0`: `gap--`.
- Else if `pending`, `enable` and any free slot:
  - pick the first free slot searching `ptr`, `ptr+1`, … with wrap mod SLOT_NUM;
  - set `busy[s]` and `slot_start=1<<s`;
  - pulse `drop_ack`, clear `pending`, go to `HOLD`.
- Else if `pending` and all slots busy: `miss_count++` (saturating), clear `pending`.

**FSM `HOLD`,** on the next tick:
- `slot_start=0`;
- `ptr=(s+1) mod SLOT_NUM`;
- `gap=MIN_GAP`;
- go to `IDLE`.

**Completion.** On any tick, `slot_done[i]=1` clears `busy[i]`, with two exceptions:
- `slot_done` on a non-busy slot is ignored.
- `slot_done` on the slot held in `HOLD` is ignored (the barrel has not launched yet).

**Free-slot mask.** The mask used for selection is `~busy` before this tick's completions are applied; a slot freed on tick T is grantable from tick T+1.

**Disable.** `enable` dropping during `HOLD` still completes `HOLD` normally. A pending event survives `enable=0` and is granted once `enable` returns.

**Widths.**
- `ptr` and slot index are `$clog2(SLOT_NUM)` bits.
- `gap` is `$clog2(MIN_GAP+1)` bits.
- `active_count` is recomputed from next-state `busy` and registered with it.

## Timing
- Edge-to-grant latency: a drop event captured on tick T is granted on the same tick T when `IDLE`, `gap=0` and a slot is free. Otherwise it is granted on the first later tick meeting those conditions.
- `slot_start` rises one `clk` after the grant tick and falls one `clk` after the following tick. The barrel therefore sees `start` high at exactly one slow-clock edge.
- `drop_ack` is high for exactly one `clk`, the cycle after the grant tick.
- Minimum launch spacing is 2 + MIN_GAP ticks: grant, HOLD, then MIN_GAP countdown ticks.
- `busy` and `active_count` update one `clk` after the tick that changes them.
- `clear` wins over every same-cycle event.
- `rst` asserted mid-`HOLD` removes `slot_start` asynchronously.

## Structure
- Package `barrel_pkg`:
  - FSM state enum (`IDLE`, `HOLD`);
  - `SLOT_NUM_DEFAULT`;
  - barrel state encodings shared with the barrel instances.
- Sub-module `slot_picker`: combinational round-robin free-slot finder. Inputs `free_mask` and `ptr`; outputs `found` and `idx`. It is implemented as a rotate, priority-encode, then un-rotate.
- Everything else is in `barrel_spawner`.

## Test plan
- **Basic grant.** After reset, `enable=1`, `drop_req` rises before tick 3:
  - tick 3: `slot_start=16'h0001` and `drop_ack` pulses;
  - tick 4: `slot_start` clears;
  - `busy=16'h0001`, `active_count=1`.
- **Round-robin and gap.** Drop events at ticks 3 and 5 (MIN_GAP=8):
  - second grant occurs at tick 13 to slot 1;
  - `miss_count` stays 0.
- **Full pool.** Preload all 16 busy, then one drop event:
  - `miss_count=1` and no `slot_start`;
  - `slot_done[5]` on the next tick, then a new event → slot 5 granted.
- **Double event while pending.** During gap, two drop edges → one grant after the gap, `miss_count=1`.
- **Saturation.** 300 misses with the pool full → `miss_count=255`.
- **Reset and clear during HOLD.**
  - `rst` pulse mid-`HOLD` → `slot_start=0` immediately and all outputs zero.
  - `clear` mid-`HOLD` → same result one `clk` later.
  - A later event is granted to slot 0.
